sin_acq: RTL and testbench
==========================

Name: sin_acq

Overview:
- Acquisition end of the sine stimulus path: consumes the generator's start_conv / new_period / halfcycle strobes and runs one serial-ADC conversion per start_conv rising edge.
- Each sample is signed and accumulated with a +/- weight set by halfcycle, giving synchronous detection over one stimulus period.
- At each new_period the per-period sum is published with a valid strobe.
- Sits between the sine generator / DAC loop and the downstream measurement logic.

Parameters:
- ADC_W, 12, ADC sample width in bits, offset-binary coded.
- ACC_W, 18, signed accumulator/result width.
- SAMPLES, 32, expected conversions per stimulus period.
- CNT_W, 6, width of the sample counter (must hold SAMPLES).
- CONV_PULSE, 4, adc_convst high time in clk cycles.
- CONV_WAIT, 40, clk cycles from convst falling to the start of readout.
- SCLK_DIV, 2, clk cycles per adc_sclk half-period.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- enable, in, 1, accept new triggers and period boundaries.
- start_conv, in, 1, level from the generator; its rising edge is the trigger.
- new_period, in, 1, level from the generator; its rising edge marks the period boundary.
- halfcycle, in, 1, 1 = positive half (add), 0 = negative half (subtract).
- adc_convst, out, 1, ADC conversion start.
- adc_cs_n, out, 1, ADC chip select, active low.
- adc_sclk, out, 1, ADC serial clock.
- adc_sdata, in, 1, ADC serial data, MSB first.
- result, out, ACC_W, signed sum of the last closed period.
- result_valid, out, 1, one-cycle strobe when result updates.
- result_cnt, out, CNT_W, samples in the last closed period.
- frame_err, out, 1, last closed period had result_cnt != SAMPLES.
- overrun, out, 1, sticky: a trigger arrived while busy.
- busy, out, 1, FSM not in IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: adc_convst=0, adc_cs_n=1, adc_sclk=0, result=0, result_valid=0, result_cnt=0, frame_err=0, overrun=0, busy=0.
  - Internal: FSM=IDLE, accumulator=0, sample counter=0, pending_close=0, edge-detect registers=0.
  - Reset mid-conversion aborts the conversion immediately; no partial sample is accumulated.
- Edge detect: registered copies start_d and np_d.
  - trig = start_conv & ~start_d & enable.
  - pclose = new_period & ~np_d & enable.
- pclose sets pending_close.
- Period close: happens in the first cycle with FSM=IDLE and pending_close=1. In that cycle:
  - result <= acc; result_cnt <= cnt; frame_err <= (cnt != SAMPLES); result_valid=1 for that cycle only.
  - acc <= 0; cnt <= 0; pending_close <= 0.
- Simultaneous new_period and start_conv edges: the close occurs in the trigger cycle. The triggered sample belongs to the new period.
- trig while busy: trigger dropped, overrun <= 1. overrun clears only on rst.
- FSM states:
  - IDLE: on trig, latch hc_l <= halfcycle and go to CONVST.
  - CONVST: adc_convst=1 for CONV_PULSE cycles, then WAIT.
  - WAIT: CONV_WAIT cycles, then READ.
  - READ: adc_cs_n=0. adc_sclk toggles every SCLK_DIV cycles starting low. adc_sdata is shifted in on each sclk rising edge; ADC_W rising edges total. After the last falling edge, go to ACC with cs_n returning high.
  - ACC (1 cycle): s = {~raw[MSB], raw[MSB-1:0]} sign-extended to ACC_W. acc <= hc_l ? acc+s : acc-s. cnt <= cnt+1, saturating at all-ones. Then IDLE.
- Trigger-to-ACC latency: 1 + CONV_PULSE + CONV_WAIT + 2*SCLK_DIV*ADC_W cycles (93 with defaults).
- Arithmetic: two's complement, wrap on overflow. The defaults cannot overflow: 32 * 2048 < 2^17.
- enable=0: triggers and boundaries are ignored; an in-flight conversion still completes and accumulates.

Decomposition:
- Shared package (sin_acq_pkg):
  - FSM state enum: IDLE, CONVST, WAIT, READ, ACC.
  - Default constants: ADC_W, ACC_W, SAMPLES.
  - Offset-binary-to-signed conversion function.
- One natural sub-module, adc_serial_rd: serial readout with its own sclk divider, cs_n control and shift register, plus start/done handshake.

Test Plan:
- Reset, then one generator period with an ADC model returning a constant 0xC00 -> result=0, result_cnt=32, frame_err=0, result_valid pulsed once.
- ADC model returns 0xFFF while halfcycle=1 and 0x000 while halfcycle=0 -> result = 16*2047 + 16*2048 = 65520.
- ADC model returns 0xC00 while halfcycle=1 and 0x400 while halfcycle=0 -> result=32768. Check trigger-to-ACC latency = 93 cycles and that exactly 12 sclk rising edges occur per conversion.
- Second start_conv edge 20 cycles after the first -> overrun=1, that sample is not counted, the next closed frame has result_cnt=31 and frame_err=1.
- rst asserted mid-READ -> next cycle adc_cs_n=1, adc_sclk=0, busy=0, result=0; the following period closes cleanly with result_cnt=32.
- enable=0 for a whole period -> no result_valid pulse; the in-flight conversion completes; after re-enable the first close reports only the samples taken while enabled.

Source files
------------

// File: rtl/sin_acq_pkg.sv
// Shared types and helpers for the sine-stimulus acquisition path.
package sin_acq_pkg;

  localparam int unsigned DefAdcW   = 12;
  localparam int unsigned DefAccW   = 18;
  localparam int unsigned DefSamples = 32;

  typedef enum logic [2:0] {
    StIdle,
    StConvst,
    StWait,
    StRead,
    StAcc
  } state_e;

  // Offset-binary sample of width w -> two's complement, sign-extended to 32 bits.
  function automatic logic signed [31:0] ob_to_signed(input logic [31:0] raw,
                                                      input int unsigned w);
    logic [31:0] v;
    int unsigned sh;
    v  = raw ^ (32'd1 << (w - 1));
    sh = 32 - w;
    return $signed(v << sh) >>> sh;
  endfunction

endpackage

// File: rtl/adc_serial_rd.sv
// Serial ADC readout: cs_n framing, divided sclk starting low, MSB-first shift on sclk rise.
module adc_serial_rd #(
  parameter int unsigned ADC_W    = 12,
  parameter int unsigned SCLK_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sdata_i,
  output logic             cs_n_o,
  output logic             sclk_o,
  output logic [ADC_W-1:0] data_o,
  output logic             done_o
);

  localparam int unsigned DivW  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned HalfW = $clog2(2 * ADC_W);

  logic             active_q;
  logic             sclk_q;
  logic [DivW-1:0]  div_q;
  logic [HalfW-1:0] half_q;
  logic [ADC_W-1:0] shift_q;
  logic             div_wrap;
  logic             last_half;

  always_comb begin
    div_wrap  = (div_q == DivW'(SCLK_DIV - 1));
    last_half = (half_q == HalfW'(2 * ADC_W - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      div_q    <= '0;
      half_q   <= '0;
      shift_q  <= '0;
    end else if (start_i && !active_q) begin
      active_q <= 1'b1;
      sclk_q   <= 1'b0;
      div_q    <= '0;
      half_q   <= '0;
    end else if (active_q) begin
      if (div_wrap) begin
        div_q  <= '0;
        sclk_q <= ~sclk_q;
        if (!sclk_q) begin
          shift_q <= {shift_q[ADC_W-2:0], sdata_i};
        end
        // The last toggle is the final falling edge; cs_n releases with it.
        if (last_half) begin
          active_q <= 1'b0;
        end else begin
          half_q <= half_q + 1'b1;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  always_comb begin
    cs_n_o = ~active_q;
    sclk_o = sclk_q;
    data_o = shift_q;
    done_o = active_q && div_wrap && last_half;
  end

endmodule

// File: rtl/sin_acq.sv
// Acquisition FSM: one ADC conversion per start_conv edge, +/- accumulation per half-cycle,
// per-period result published on each new_period edge.
module sin_acq
  import sin_acq_pkg::*;
#(
  parameter int unsigned ADC_W      = DefAdcW,
  parameter int unsigned ACC_W      = DefAccW,
  parameter int unsigned SAMPLES    = DefSamples,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned CONV_PULSE = 4,
  parameter int unsigned CONV_WAIT  = 40,
  parameter int unsigned SCLK_DIV   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             start_conv_i,
  input  logic             new_period_i,
  input  logic             halfcycle_i,
  output logic             adc_convst_o,
  output logic             adc_cs_n_o,
  output logic             adc_sclk_o,
  input  logic             adc_sdata_i,
  output logic [ACC_W-1:0] result_o,
  output logic             result_valid_o,
  output logic [CNT_W-1:0] result_cnt_o,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             busy_o
);

  localparam int unsigned TmrMax = (CONV_WAIT > CONV_PULSE) ? CONV_WAIT : CONV_PULSE;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  state_e           state_q;
  logic [TmrW-1:0]  tmr_q;
  logic             start_d_q;
  logic             np_d_q;
  logic             pending_q;
  logic             hc_q;
  logic             convst_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] result_q;
  logic [CNT_W-1:0] result_cnt_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             overrun_q;

  logic             trig;
  logic             pclose;
  logic             close;
  logic             rd_start;
  logic             rd_done;
  logic [ADC_W-1:0] rd_data;
  logic [ACC_W-1:0] samp;

  always_comb begin
    trig     = start_conv_i & ~start_d_q & enable_i;
    pclose   = new_period_i & ~np_d_q & enable_i;
    close    = (state_q == StIdle) && (pending_q || pclose);
    rd_start = (state_q == StWait) && (tmr_q == TmrW'(CONV_WAIT - 1));
    samp     = ACC_W'(ob_to_signed(32'(rd_data), ADC_W));
  end

  adc_serial_rd #(
    .ADC_W    (ADC_W),
    .SCLK_DIV (SCLK_DIV)
  ) u_rd (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (rd_start),
    .sdata_i (adc_sdata_i),
    .cs_n_o  (adc_cs_n_o),
    .sclk_o  (adc_sclk_o),
    .data_o  (rd_data),
    .done_o  (rd_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      tmr_q        <= '0;
      start_d_q    <= 1'b0;
      np_d_q       <= 1'b0;
      pending_q    <= 1'b0;
      hc_q         <= 1'b0;
      convst_q     <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      result_cnt_q <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      start_d_q <= start_conv_i;
      np_d_q    <= new_period_i;
      valid_q   <= 1'b0;
      if (pclose) begin
        pending_q <= 1'b1;
      end
      if (trig && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          // Close before the trigger so a coincident sample lands in the new period.
          if (close) begin
            result_q     <= acc_q;
            result_cnt_q <= cnt_q;
            frame_err_q  <= (cnt_q != CNT_W'(SAMPLES));
            valid_q      <= 1'b1;
            acc_q        <= '0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
          end
          if (trig) begin
            hc_q     <= halfcycle_i;
            convst_q <= 1'b1;
            tmr_q    <= '0;
            state_q  <= StConvst;
          end
        end
        StConvst: begin
          if (tmr_q == TmrW'(CONV_PULSE - 1)) begin
            convst_q <= 1'b0;
            tmr_q    <= '0;
            state_q  <= StWait;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        StWait: begin
          if (rd_start) begin
            tmr_q   <= '0;
            state_q <= StRead;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        StRead: begin
          if (rd_done) begin
            state_q <= StAcc;
          end
        end
        StAcc: begin
          acc_q   <= hc_q ? (acc_q + samp) : (acc_q - samp);
          cnt_q   <= (&cnt_q) ? cnt_q : (cnt_q + 1'b1);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    adc_convst_o   = convst_q;
    result_o       = result_q;
    result_valid_o = valid_q;
    result_cnt_o   = result_cnt_q;
    frame_err_o    = frame_err_q;
    overrun_o      = overrun_q;
    busy_o         = (state_q != StIdle);
  end

endmodule

// File: tb/tb_sin_acq.sv
// Directed bench for sin_acq with a behavioural serial ADC driven by halfcycle.
module tb_sin_acq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        start_conv = 1'b0;
  logic        new_period = 1'b0;
  logic        halfcycle = 1'b0;
  logic        adc_convst;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_sdata;
  logic [17:0] result;
  logic        result_valid;
  logic [5:0]  result_cnt;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  logic [11:0] hi_w = 12'hC00;
  logic [11:0] lo_w = 12'hC00;
  logic [11:0] word;
  logic [3:0]  bit_idx = 4'd0;
  logic        sclk_p = 1'b0;
  int          rise_run = 0;
  int          last_rise = 0;
  int          busy_run = 0;
  int          last_busy = 0;
  int          valid_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  sin_acq u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .start_conv_i   (start_conv),
    .new_period_i   (new_period),
    .halfcycle_i    (halfcycle),
    .adc_convst_o   (adc_convst),
    .adc_cs_n_o     (adc_cs_n),
    .adc_sclk_o     (adc_sclk),
    .adc_sdata_i    (adc_sdata),
    .result_o       (result),
    .result_valid_o (result_valid),
    .result_cnt_o   (result_cnt),
    .frame_err_o    (frame_err),
    .overrun_o      (overrun),
    .busy_o         (busy)
  );

  // ADC model: MSB presented at cs_n fall, next bit after each sclk fall.
  assign word      = halfcycle ? hi_w : lo_w;
  assign adc_sdata = (bit_idx < 4'd12) ? word[4'd11 - bit_idx] : 1'b0;

  always @(negedge clk) begin
    sclk_p <= adc_sclk;
    if (adc_cs_n) bit_idx <= 4'd0;
    else if (sclk_p && !adc_sclk) bit_idx <= bit_idx + 4'd1;
    if (!adc_cs_n && adc_sclk && !sclk_p) rise_run <= rise_run + 1;
    if (adc_cs_n && rise_run != 0) begin
      last_rise <= rise_run;
      rise_run  <= 0;
    end
    if (busy) busy_run <= busy_run + 1;
    else if (busy_run != 0) begin
      last_busy <= busy_run;
      busy_run  <= 0;
    end
    if (result_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic trig_one(input logic hc);
    halfcycle  = hc;
    start_conv = 1'b1;
    wait_cyc(10);
    start_conv = 1'b0;
    wait_cyc(90);
  endtask

  // Second rising edge 20 cycles after the first, while the conversion is in flight.
  task automatic trig_double(input logic hc);
    halfcycle  = hc;
    start_conv = 1'b1;
    wait_cyc(10);
    start_conv = 1'b0;
    wait_cyc(10);
    start_conv = 1'b1;
    wait_cyc(10);
    start_conv = 1'b0;
    wait_cyc(70);
  endtask

  task automatic np_pulse();
    new_period = 1'b1;
    wait_cyc(10);
    new_period = 1'b0;
    wait_cyc(10);
  endtask

  task automatic full_period();
    for (int i = 0; i < 32; i++) trig_one(i < 16);
  endtask

  int v0;
  int tmo;

  initial begin
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);
    check("rst_convst", 32'(adc_convst), 32'd0);
    check("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("rst_sclk", 32'(adc_sclk), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_cnt", 32'(result_cnt), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    enable = 1'b1;
    np_pulse();
    check("empty_valid", 32'(valid_cnt), 32'd1);
    check("empty_cnt", 32'(result_cnt), 32'd0);
    check("empty_ferr", 32'(frame_err), 32'd1);

    // Constant 0xC00 (+1024): 16 adds cancel 16 subtracts.
    hi_w = 12'hC00; lo_w = 12'hC00;
    v0 = valid_cnt;
    full_period();
    np_pulse();
    check("t1_valid_once", 32'(valid_cnt - v0), 32'd1);
    check("t1_result", 32'(result), 32'd0);
    check("t1_cnt", 32'(result_cnt), 32'd32);
    check("t1_ferr", 32'(frame_err), 32'd0);

    // +2047 added 16x, -2048 subtracted 16x.
    hi_w = 12'hFFF; lo_w = 12'h000;
    full_period();
    np_pulse();
    check("t2_result", 32'(result), 32'd65520);
    check("t2_cnt", 32'(result_cnt), 32'd32);

    hi_w = 12'hC00; lo_w = 12'h400;
    trig_one(1'b1);
    check("t3_latency", 32'(last_busy), 32'd93);
    check("t3_sclk_rises", 32'(last_rise), 32'd12);
    for (int i = 1; i < 32; i++) trig_one(i < 16);
    np_pulse();
    check("t3_result", 32'(result), 32'd32768);
    check("t3_cnt", 32'(result_cnt), 32'd32);
    check("t3_no_overrun", 32'(overrun), 32'd0);

    // 31 counted samples at +/-1024: 16 adds, 15 subtracts.
    hi_w = 12'hC00; lo_w = 12'hC00;
    for (int i = 0; i < 31; i++) begin
      if (i == 5) trig_double(1'b1);
      else trig_one(i < 16);
    end
    np_pulse();
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_result", 32'(result), 32'd1024);
    check("t4_cnt", 32'(result_cnt), 32'd31);
    check("t4_ferr", 32'(frame_err), 32'd1);

    // Reset in the middle of the serial readout.
    halfcycle  = 1'b1;
    start_conv = 1'b1;
    wait_cyc(10);
    start_conv = 1'b0;
    tmo = 0;
    while (adc_cs_n && tmo < 200) begin
      wait_cyc(1);
      tmo++;
    end
    check("t5_reached_read", 32'(adc_cs_n), 32'd0);
    wait_cyc(7);
    rst = 1'b1;
    wait_cyc(1);
    check("t5_cs_n", 32'(adc_cs_n), 32'd1);
    check("t5_sclk", 32'(adc_sclk), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_result", 32'(result), 32'd0);
    check("t5_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    wait_cyc(100);
    np_pulse();
    check("t5_close_cnt0", 32'(result_cnt), 32'd0);
    full_period();
    np_pulse();
    check("t5_cnt", 32'(result_cnt), 32'd32);
    check("t5_ferr", 32'(frame_err), 32'd0);

    // Disable during a conversion, then a whole period while disabled.
    np_pulse();
    halfcycle  = 1'b1;
    start_conv = 1'b1;
    wait_cyc(10);
    start_conv = 1'b0;
    wait_cyc(10);
    enable = 1'b0;
    wait_cyc(80);
    check("t6_inflight_done", 32'(last_busy), 32'd93);
    v0 = valid_cnt;
    np_pulse();
    full_period();
    np_pulse();
    check("t6_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    wait_cyc(2);
    for (int i = 0; i < 3; i++) trig_one(1'b1);
    np_pulse();
    check("t6_valid", 32'(valid_cnt - v0), 32'd1);
    check("t6_result", 32'(result), 32'd4096);
    check("t6_cnt", 32'(result_cnt), 32'd4);
    check("t6_ferr", 32'(frame_err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
